// File: rtl/aes_key_expansion_if.sv
// Request/response bundle between the key schedule and its consumer.
// The master drives start/cipher_key. The slave returns status and the eleven round keys.
interface aes_key_expansion_if;
    logic         start;
    logic [0:127] cipher_key;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [0:127] key_0;
    logic [0:127] key_1;
    logic [0:127] key_2;
    logic [0:127] key_3;
    logic [0:127] key_4;
    logic [0:127] key_5;
    logic [0:127] key_6;
    logic [0:127] key_7;
    logic [0:127] key_8;
    logic [0:127] key_9;
    logic [0:127] key_10;

    modport master (
        output start, cipher_key,
        input  busy, done, key_valid,
        input  key_0, key_1, key_2, key_3, key_4, key_5,
        input  key_6, key_7, key_8, key_9, key_10
    );

    modport slave (
        input  start, cipher_key,
        output busy, done, key_valid,
        output key_0, key_1, key_2, key_3, key_4, key_5,
        output key_6, key_7, key_8, key_9, key_10
    );
endinterface

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule that produces one round key per clock.
// All eleven round keys stay held until the next accepted start.
//
// state    | meaning
// S_IDLE   | waiting for start; round keys held, key_valid reflects last run
// S_EXPAND | writing key_1..key_10, one per clock
module aes_key_expansion (
    input  logic              clk,
    input  logic              rst_n,
    aes_key_expansion_if.slave kx
);

    typedef enum logic {S_IDLE, S_EXPAND} state_t;

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    state_t       r_state;
    logic [0:127] r_key [0:10];
    logic [0:127] r_last_key;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic         r_busy;
    logic         r_done;
    logic         r_key_valid;

    logic [0:31]  w_w3;
    logic [0:31]  w_rot;
    logic [0:31]  w_sub;
    logic [0:31]  w_t;
    logic [0:31]  w_n0;
    logic [0:31]  w_n1;
    logic [0:31]  w_n2;
    logic [0:31]  w_n3;
    logic [0:127] w_next_key;
    logic [7:0]   w_rcon_next;

    assign w_w3  = r_last_key[96:127];
    assign w_rot = {w_w3[8:31], w_w3[0:7]};
    assign w_sub = {sbox(w_rot[0:7]), sbox(w_rot[8:15]),
                    sbox(w_rot[16:23]), sbox(w_rot[24:31])};
    assign w_t   = w_sub ^ {r_rcon, 24'h000000};

    assign w_n0 = r_last_key[0:31]   ^ w_t;
    assign w_n1 = r_last_key[32:63]  ^ w_n0;
    assign w_n2 = r_last_key[64:95]  ^ w_n1;
    assign w_n3 = r_last_key[96:127] ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // r_last_key mirrors the most recent write so the datapath never muxes across the key bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_key       <= '{default: '0};
            r_last_key  <= '0;
            r_round     <= '0;
            r_rcon      <= 8'h01;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (kx.start) begin
                        r_key[0]    <= kx.cipher_key;
                        r_last_key  <= kx.cipher_key;
                        r_round     <= 4'd1;
                        r_rcon      <= 8'h01;
                        r_busy      <= 1'b1;
                        r_key_valid <= 1'b0;
                        r_state     <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    for (int i = 1; i <= 10; i++) begin
                        if (r_round == 4'(i)) r_key[i] <= w_next_key;
                    end
                    r_last_key <= w_next_key;
                    r_rcon     <= w_rcon_next;
                    r_round    <= r_round + 4'd1;
                    if (r_round == 4'd10) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_key_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign kx.busy      = r_busy;
    assign kx.done      = r_done;
    assign kx.key_valid = r_key_valid;
    assign kx.key_0     = r_key[0];
    assign kx.key_1     = r_key[1];
    assign kx.key_2     = r_key[2];
    assign kx.key_3     = r_key[3];
    assign kx.key_4     = r_key[4];
    assign kx.key_5     = r_key[5];
    assign kx.key_6     = r_key[6];
    assign kx.key_7     = r_key[7];
    assign kx.key_8     = r_key[8];
    assign kx.key_9     = r_key[9];
    assign kx.key_10    = r_key[10];

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for the AES-128 key schedule.
// The reference derives the S-box from GF(2^8) inversion and expands keys word by word.
module tb_aes_key_expansion;

    logic clk;
    logic rst_n;

    aes_key_expansion_if kx();

    aes_key_expansion u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kx    (kx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0][127:0] keys;
        int                 acc;
    } exp_t;

    exp_t       q[$];
    exp_t       e_mon;
    int         checks = 0;
    int         passed = 0;
    int         edge_cnt = 0;
    bit         done_prev = 1'b0;
    logic [7:0] sbox_m [256];

    localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_K1    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_K10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] A1_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] A1_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [10:0][127:0] model_expand(input logic [127:0] key);
        logic [31:0]        w [44];
        logic [31:0]        t;
        logic [7:0]         rc = 8'h01;
        logic [10:0][127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) out[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return out;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt,
                                                   input logic [10:0][127:0] rk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] st;
        st = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[st[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = s[i];
            st ^= rk[r];
        end
        return st;
    endfunction

    function automatic logic [10:0][127:0] dut_keys();
        return {kx.key_10, kx.key_9, kx.key_8, kx.key_7, kx.key_6, kx.key_5,
                kx.key_4, kx.key_3, kx.key_2, kx.key_1, kx.key_0};
    endfunction

    // Called at a falling edge; the following rising edge accepts the key.
    task automatic run_start(input logic [127:0] key);
        exp_t e;
        e.keys = model_expand(key);
        e.acc  = edge_cnt + 1;
        q.push_back(e);
        kx.start      = 1'b1;
        kx.cipher_key = key;
        @(negedge clk);
        kx.start = 1'b0;
        chk("accept_busy", 128'(kx.busy), 128'd1);
        chk("accept_key0", 128'(kx.key_0), key);
        chk("accept_kv_low", 128'(kx.key_valid), 128'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev <= 1'b0;
        end else begin
            if (done_prev) chk("done_one_cycle", 128'(kx.done), 128'd0);
            done_prev <= kx.done;
            if (q.size() != 0 && edge_cnt > q[0].acc + 10) begin
                checks++;
                $display("FAIL done_missing: got no done by edge %0d expected at edge %0d",
                         edge_cnt, q[0].acc + 10);
                void'(q.pop_front());
            end
            if (kx.done) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done=1 at edge %0d expected none", edge_cnt);
                end else begin
                    e_mon = q.pop_front();
                    chk("done_latency", 128'(edge_cnt), 128'(e_mon.acc + 10));
                    for (int r = 0; r < 11; r++)
                        chk($sformatf("round_key_%0d", r), dut_keys()[r], e_mon.keys[r]);
                    chk("done_key_valid", 128'(kx.key_valid), 128'd1);
                    chk("done_busy_low", 128'(kx.busy), 128'd0);
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        kx.start      = 1'b0;
        kx.cipher_key = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(kx.busy), 128'd0);
        chk("rst_done", 128'(kx.done), 128'd0);
        chk("rst_kv", 128'(kx.key_valid), 128'd0);
        chk("rst_key10", kx.key_10, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1 with known answers and a full encryption through the held keys
        run_start(A1_KEY);
        repeat (10) @(negedge clk);
        chk("a1_key1", kx.key_1, A1_K1);
        chk("a1_key10", kx.key_10, A1_K10);
        chk("a1_encrypt", model_encrypt(A1_PT, dut_keys()), A1_CT);
        @(negedge clk);
        chk("a1_kv_hold", 128'(kx.key_valid), 128'd1);

        run_start(128'd0);
        repeat (10) @(negedge clk);
        chk("zero_key1", kx.key_1, Z_K1);
        chk("zero_key10", kx.key_10, Z_K10);
        @(negedge clk);

        // starts while busy must be ignored
        run_start({$urandom, $urandom, $urandom, $urandom});
        repeat (2) @(negedge clk);
        kx.start = 1'b1; kx.cipher_key = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        kx.start = 1'b0;
        repeat (3) @(negedge clk);
        kx.start = 1'b1; kx.cipher_key = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        kx.start = 1'b0;
        chk("ignored_busy", 128'(kx.busy), 128'd1);
        repeat (4) @(negedge clk);

        for (int n = 0; n < 5; n++) begin
            run_start({$urandom, $urandom, $urandom, $urandom});
            repeat (10 + $urandom_range(0, 3)) @(negedge clk);
        end

        // asynchronous reset after key_4 has been written
        run_start({$urandom, $urandom, $urandom, $urandom});
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 128'(kx.busy), 128'd0);
        chk("async_kv", 128'(kx.key_valid), 128'd0);
        for (int r = 0; r < 11; r++) chk($sformatf("async_key_%0d", r), dut_keys()[r], 128'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_start(A1_KEY);
        repeat (10) @(negedge clk);
        chk("post_rst_key10", kx.key_10, A1_K10);
        @(negedge clk);

        // back-to-back: zero key presented during the done cycle of an A.1 run
        run_start(A1_KEY);
        repeat (10) @(negedge clk);
        begin
            exp_t e;
            e.keys = model_expand(128'd0);
            e.acc  = edge_cnt + 1;
            q.push_back(e);
        end
        kx.start = 1'b1; kx.cipher_key = 128'd0;
        @(negedge clk);
        kx.start = 1'b0;
        chk("b2b_accept_busy", 128'(kx.busy), 128'd1);
        chk("b2b_kv_low", 128'(kx.key_valid), 128'd0);
        repeat (9) @(negedge clk);
        chk("b2b_kv_still_low", 128'(kx.key_valid), 128'd0);
        @(negedge clk);
        chk("b2b_kv_high", 128'(kx.key_valid), 128'd1);
        chk("b2b_key10", kx.key_10, Z_K10);

        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 128'(q.size()), 128'd0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
